// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
//   Iterative radix-2 restoring divider. It serves the execute stage's
//   en/done/is_flush/is_stall divide handshake and produces one quotient bit
//   per cycle. Signed operation divides the operand magnitudes and then
//   applies sign correction: the quotient truncates toward zero and the
//   remainder takes the sign of the dividend.
//
//   Latency: en is accepted at edge T. WIDTH iterations run at edges
//   T+1..T+WIDTH. The results are sign-corrected and registered at edge
//   T+WIDTH+1, together with done=1.
//
// Ports
//   clk        clock; all state changes on posedge
//   rst        synchronous reset, active-high
//   is_flush   abort the current operation; in IDLE it also blocks en
//   is_stall   consumer not ready; holds done and the results in DONE
//   en         start request, sampled only in IDLE
//   is_signed  1 = two's-complement operands, sampled with en
//   dividend   dividend, sampled with en
//   divisor    divisor, sampled with en
//   quotient   result, valid while done=1
//   remainder  result, valid while done=1
//   done       result valid (registered)
// -----------------------------------------------------------------------------
module iter_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             is_flush,
   input  logic             is_stall,
   input  logic             en,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem_p0;      // partial remainder
   logic [WIDTH-1:0] quo_p0;      // dividend bits shift out as quotient bits shift in
   logic [WIDTH-1:0] dvs_mag_p0;  // divisor magnitude
   logic             sign_q;
   logic             sign_r;
   logic [WIDTH:0]   trial_p0;

   // Magnitude of an operand. Only a signed operand with its MSB set is
   // negated. The most negative value maps onto itself, which is the correct
   // unsigned magnitude 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                            input logic sgn);
      logic signed [WIDTH-1:0] neg_v;
      neg_v = -v;
      return (sgn && v[WIDTH-1]) ? $unsigned(neg_v) : $unsigned(v);
   endfunction

   // Final sign correction of a magnitude result.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic neg);
      logic signed [WIDTH-1:0] neg_v;
      neg_v = -$signed(v);
      return neg ? $unsigned(neg_v) : v;
   endfunction

   // The trial subtraction is WIDTH+1 bits wide because the shifted remainder
   // can reach 2*divisor-1. Bit WIDTH set means the subtraction went negative.
   assign trial_p0 = {rem_p0, quo_p0[WIDTH-1]} - {1'b0, dvs_mag_p0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (!is_flush && en) begin
                  quo_p0     <= mag($signed(dividend), is_signed);
                  dvs_mag_p0 <= mag($signed(divisor), is_signed);
                  rem_p0     <= '0;
                  sign_q     <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  sign_r     <= is_signed & dividend[WIDTH-1];
                  count      <= '0;
                  state      <= BUSY;
               end
            end
            // ---- iteration stage: one quotient bit per cycle ----
            BUSY: begin
               if (is_flush) begin
                  state <= IDLE;
               end else if (count == LAST) begin
                  quotient  <= cond_neg(quo_p0, sign_q);
                  remainder <= cond_neg(rem_p0, sign_r);
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  if (!trial_p0[WIDTH]) begin
                     rem_p0 <= trial_p0[WIDTH-1:0];
                     quo_p0 <= {quo_p0[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_p0 <= {rem_p0[WIDTH-2:0], quo_p0[WIDTH-1]};
                     quo_p0 <= {quo_p0[WIDTH-2:0], 1'b0};
                  end
                  count <= count + CNT_ONE;
               end
            end
            // ---- result stage: hold until the consumer takes it ----
            DONE: begin
               if (is_flush || !is_stall) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
